// File: rtl/odds_pkg.sv
// Shared types and defaults for the odds window selector.
package odds_pkg;

    localparam int DEF_LANES = 10;

    typedef enum logic [1:0] {
        MODE_THERM  = 2'd0,
        MODE_ONEHOT = 2'd1,
        MODE_TOP    = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } state_e;

endpackage

// File: rtl/odds_mask_gen.sv
// Combinational bet-to-mask decoder with a legality flag.
module odds_mask_gen
    import odds_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int BET_W = $clog2(LANES + 1)
) (
    input  logic [BET_W-1:0] bet,
    input  mode_e            mode,
    output logic [LANES-1:0] mask,
    output logic             legal
);

    int b;

    always_comb begin
        b     = int'(bet);
        legal = (b <= LANES) && (mode != MODE_RSVD);
        mask  = '0;
        for (int i = 0; i < LANES; i++) begin
            case (mode)
                MODE_THERM:  mask[i] = (i < b);
                MODE_ONEHOT: mask[i] = (i == b - 1);
                MODE_TOP:    mask[i] = (i >= LANES - b);
                default:     mask[i] = 1'b0;
            endcase
        end
        // A rejected bet never reaches the pending register, but keep it quiet anyway.
        if (!legal) mask = '0;
    end

endmodule

// File: rtl/odds_window_selector.sv
// Bet handshake, one-deep pending register and roll-driven payout window.
module odds_window_selector
    import odds_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int BET_W  = $clog2(LANES + 1),
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bet_valid,
    output logic              bet_ready,
    input  logic [BET_W-1:0]  bet,
    input  logic [1:0]        bet_mode,
    input  logic [HOLD_W-1:0] hold,
    input  logic              roll,
    input  logic              cancel,
    output logic [LANES-1:0]  en,
    output logic              active,
    output logic [HOLD_W-1:0] rolls_left,
    output logic              bet_err
);

    state_e             state_q, state_d;
    logic [LANES-1:0]   en_q, en_d;
    logic [HOLD_W-1:0]  rolls_left_q, rolls_left_d;
    logic               bet_err_q, bet_err_d;
    logic               pend_v_q, pend_v_d;
    logic [LANES-1:0]   pend_mask_q, pend_mask_d;
    logic [HOLD_W-1:0]  pend_hold_q, pend_hold_d;

    logic [LANES-1:0]   new_mask;
    logic               new_legal;
    logic               hs, accept, reject;

    odds_mask_gen #(.LANES(LANES), .BET_W(BET_W)) u_mask_gen (
        .bet   (bet),
        .mode  (mode_e'(bet_mode)),
        .mask  (new_mask),
        .legal (new_legal)
    );

    assign bet_ready = !pend_v_q;
    assign hs        = bet_valid && bet_ready;
    assign accept    = hs && new_legal && !cancel;
    assign reject    = hs && !new_legal && !cancel;

    always_comb begin
        state_d      = state_q;
        en_d         = en_q;
        rolls_left_d = rolls_left_q;
        pend_v_d     = pend_v_q;
        pend_mask_d  = pend_mask_q;
        pend_hold_d  = pend_hold_q;
        bet_err_d    = reject;

        if (cancel) begin
            state_d      = IDLE;
            en_d         = '0;
            rolls_left_d = '0;
            pend_v_d     = 1'b0;
        end else begin
            case (state_q)
                ARMED: if (roll) begin
                    en_d         = pend_mask_q;
                    rolls_left_d = pend_hold_q;
                    pend_v_d     = 1'b0;
                    state_d      = ACTIVE;
                end
                ACTIVE: if (roll) begin
                    if (rolls_left_q != '0) begin
                        rolls_left_d = rolls_left_q - HOLD_W'(1);
                    end else if (pend_v_q) begin
                        en_d         = pend_mask_q;
                        rolls_left_d = pend_hold_q;
                        pend_v_d     = 1'b0;
                    end else begin
                        en_d    = '0;
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase

            // Accept only happens with pend_v=0, so it never collides with a pending load.
            if (accept) begin
                pend_mask_d = new_mask;
                pend_hold_d = hold;
                pend_v_d    = 1'b1;
                if (state_d == IDLE) state_d = ARMED;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            en_q         <= '0;
            rolls_left_q <= '0;
            bet_err_q    <= 1'b0;
            pend_v_q     <= 1'b0;
            pend_mask_q  <= '0;
            pend_hold_q  <= '0;
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            rolls_left_q <= rolls_left_d;
            bet_err_q    <= bet_err_d;
            pend_v_q     <= pend_v_d;
            pend_mask_q  <= pend_mask_d;
            pend_hold_q  <= pend_hold_d;
        end
    end

    assign en         = en_q;
    assign rolls_left = rolls_left_q;
    assign bet_err    = bet_err_q;
    assign active     = (state_q == ACTIVE);

endmodule

// File: tb/tb_odds_window_selector.sv
// Directed bench for odds_window_selector with LANES=10, HOLD_W=4.
module tb_odds_window_selector;

    localparam int LANES  = 10;
    localparam int BET_W  = 4;
    localparam int HOLD_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              bet_valid;
    logic              bet_ready;
    logic [BET_W-1:0]  bet;
    logic [1:0]        bet_mode;
    logic [HOLD_W-1:0] hold;
    logic              roll;
    logic              cancel;
    logic [LANES-1:0]  en;
    logic              active;
    logic [HOLD_W-1:0] rolls_left;
    logic              bet_err;

    int checks   = 0;
    int failures = 0;

    odds_window_selector #(.LANES(LANES), .HOLD_W(HOLD_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bet_valid  (bet_valid),
        .bet_ready  (bet_ready),
        .bet        (bet),
        .bet_mode   (bet_mode),
        .hold       (hold),
        .roll       (roll),
        .cancel     (cancel),
        .en         (en),
        .active     (active),
        .rolls_left (rolls_left),
        .bet_err    (bet_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_bet(input int b, input int m, input int h);
        bet_valid = 1'b1;
        bet       = BET_W'(b);
        bet_mode  = 2'(m);
        hold      = HOLD_W'(h);
        tick();
        bet_valid = 1'b0;
    endtask

    task automatic do_roll();
        roll = 1'b1;
        tick();
        roll = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bet_valid = 1'b0; bet = '0; bet_mode = '0; hold = '0;
        roll = 1'b0; cancel = 1'b0;
        tick(); tick();
        chk("rst_en", 32'(en), 32'h0);
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_rolls", 32'(rolls_left), 32'h0);
        chk("rst_err", 32'(bet_err), 32'h0);
        chk("rst_ready", 32'(bet_ready), 32'h1);
        rst = 1'b0;
        tick();

        // Thermometer bet 3, single roll window
        do_bet(3, 0, 0);
        chk("t1_ready_drop", 32'(bet_ready), 32'h0);
        chk("t1_armed_en", 32'(en), 32'h0);
        chk("t1_armed_act", 32'(active), 32'h0);
        do_roll();
        chk("t1_en", 32'(en), 32'h007);
        chk("t1_active", 32'(active), 32'h1);
        chk("t1_rolls", 32'(rolls_left), 32'h0);
        do_roll();
        chk("t1_exp_en", 32'(en), 32'h0);
        chk("t1_exp_act", 32'(active), 32'h0);
        chk("t1_exp_ready", 32'(bet_ready), 32'h1);

        // Top-aligned full and one-hot
        do_bet(10, 2, 0);
        do_roll();
        chk("t2_top10", 32'(en), 32'h3FF);
        do_roll();
        do_bet(4, 1, 0);
        do_roll();
        chk("t2_onehot4", 32'(en), 32'h008);
        do_roll();
        do_bet(3, 2, 0);
        do_roll();
        chk("t2_top3", 32'(en), 32'h380);
        do_roll();
        do_bet(0, 0, 0);
        do_roll();
        chk("t2_zero_en", 32'(en), 32'h0);
        chk("t2_zero_act", 32'(active), 32'h1);
        do_roll();
        chk("t2_zero_idle", 32'(active), 32'h0);

        // Rejections
        do_bet(11, 0, 0);
        chk("t3_err11", 32'(bet_err), 32'h1);
        chk("t3_ready11", 32'(bet_ready), 32'h1);
        chk("t3_en11", 32'(en), 32'h0);
        chk("t3_act11", 32'(active), 32'h0);
        tick();
        chk("t3_err_pulse", 32'(bet_err), 32'h0);
        do_bet(2, 3, 0);
        chk("t3_err_m3", 32'(bet_err), 32'h1);
        chk("t3_ready_m3", 32'(bet_ready), 32'h1);
        tick();
        chk("t3_err_m3_end", 32'(bet_err), 32'h0);
        do_roll();
        chk("t3_roll_ignored", 32'(active), 32'h0);

        // Hold 2 with a queued bet back to back
        do_bet(5, 0, 2);
        do_roll();
        chk("t4_en_r1", 32'(en), 32'h01F);
        chk("t4_rl_r1", 32'(rolls_left), 32'h2);
        do_bet(1, 0, 0);
        chk("t4_ready_pend", 32'(bet_ready), 32'h0);
        do_roll();
        chk("t4_en_r2", 32'(en), 32'h01F);
        chk("t4_rl_r2", 32'(rolls_left), 32'h1);
        do_roll();
        chk("t4_en_r3", 32'(en), 32'h01F);
        chk("t4_rl_r3", 32'(rolls_left), 32'h0);
        chk("t4_ready_still", 32'(bet_ready), 32'h0);
        do_roll();
        chk("t4_en_r4", 32'(en), 32'h001);
        chk("t4_act_r4", 32'(active), 32'h1);
        chk("t4_ready_r4", 32'(bet_ready), 32'h1);
        do_roll();
        chk("t4_idle", 32'(en), 32'h0);

        // Accept coinciding with the expiring roll
        do_bet(6, 0, 0);
        do_roll();
        chk("t5_en6", 32'(en), 32'h03F);
        bet_valid = 1'b1; bet = 4'd2; bet_mode = 2'd0; hold = 4'd0; roll = 1'b1;
        tick();
        bet_valid = 1'b0; roll = 1'b0;
        chk("t5_exp_en", 32'(en), 32'h0);
        chk("t5_exp_act", 32'(active), 32'h0);
        chk("t5_armed_ready", 32'(bet_ready), 32'h0);
        do_roll();
        chk("t5_en2", 32'(en), 32'h003);
        do_roll();

        // Cancel with roll in ARMED, and cancel against a bet accept
        do_bet(7, 0, 0);
        cancel = 1'b1; roll = 1'b1;
        tick();
        cancel = 1'b0; roll = 1'b0;
        chk("t6_cancel_en", 32'(en), 32'h0);
        chk("t6_cancel_act", 32'(active), 32'h0);
        chk("t6_cancel_ready", 32'(bet_ready), 32'h1);
        do_roll();
        chk("t6_after_roll", 32'(en), 32'h0);
        bet_valid = 1'b1; bet = 4'd4; bet_mode = 2'd0; cancel = 1'b1;
        tick();
        bet_valid = 1'b0; cancel = 1'b0;
        chk("t6_drop_ready", 32'(bet_ready), 32'h1);
        chk("t6_drop_err", 32'(bet_err), 32'h0);
        do_bet(15, 0, 0);
        cancel = 1'b0;
        chk("t6_err15", 32'(bet_err), 32'h1);

        // Cancel while ACTIVE with hold remaining
        tick();
        do_bet(8, 0, 3);
        do_roll();
        chk("t7_en8", 32'(en), 32'h0FF);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("t7_cancel_en", 32'(en), 32'h0);
        chk("t7_cancel_rl", 32'(rolls_left), 32'h0);

        // Asynchronous reset mid-round
        do_bet(9, 0, 3);
        do_roll();
        chk("t8_en9", 32'(en), 32'h1FF);
        #2 rst = 1'b1;
        #1;
        chk("t8_async_en", 32'(en), 32'h0);
        chk("t8_async_act", 32'(active), 32'h0);
        chk("t8_async_ready", 32'(bet_ready), 32'h1);
        tick();
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/odds_window_selector.md
# odds_window_selector

Parametrised successor to the fixed 10-lane odds selector. Converts a bet into a LANES-wide payout-enable mask (thermometer, one-hot or top-aligned) and holds it live for a programmable number of rolls. Range-checks bets and accepts them over a valid/ready handshake. Queues one pending bet while a mask is live, so rounds run back to back. Sits between the bet-entry controller and the per-lane payout/LED logic.

## Interface
- LANES, 10, number of enable lanes (1..15)
- BET_W, $clog2(LANES+1), bet field width
- HOLD_W, 4, width of hold count
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- bet_valid  in  1  bet offered
- bet_ready  out  1  bet can be accepted; handshake = bet_valid & bet_ready
- bet  in  BET_W  number of lanes wagered (0..LANES)
- bet_mode  in  2  0 thermometer, 1 one-hot, 2 top-aligned thermometer, 3 reserved
- hold  in  HOLD_W  extra rolls the mask stays live after the first
- roll  in  1  single-cycle roll strobe, synchronous to clk
- cancel  in  1  abort pending and live bet
- en  out  LANES  payout-enable mask
- active  out  1  mask is live
- rolls_left  out  HOLD_W  remaining rolls before the live mask clears
- bet_err  out  1  one-cycle pulse: rejected bet

## Operation
- Mask rules, with b = bet:
  - Mode 0: lanes [b-1:0] set.
  - Mode 1: only lane b-1 set.
  - Mode 2: lanes [LANES-1:LANES-b] set.
  - b=0 gives an all-zero mask in every mode. A zero bet is legal.
- Reject: b>LANES or mode 3. A rejected bet is consumed (ready stays high), bet_err pulses, and state is unchanged.
- Accept: an accepted bet latches mask and hold into the pending register, and pend_v is set. bet_ready = !pend_v.
- IDLE (pend_v=0, en=0):
  - Legal accept → ARMED.
  - A roll is ignored.
- ARMED (pend_v=1, en=0):
  - roll → en<=pending mask, rolls_left<=pending hold, pend_v<=0, go to ACTIVE.
- ACTIVE (en live):
  - roll with rolls_left>0 → rolls_left decrements; en is unchanged.
  - roll with rolls_left=0 and pend_v=1 → load the pending mask and hold, clear pend_v, stay in ACTIVE (back to back).
  - roll with rolls_left=0 and pend_v=0 → en<=0, go to IDLE.
  - A legal bet may be accepted while ACTIVE if pend_v=0.
- cancel, any state: en<=0, pend_v<=0, rolls_left<=0, go to IDLE. cancel has priority over roll and over a same-cycle bet accept. The bet is dropped and bet_err is not pulsed.
- Same-cycle accept and expiring roll (ACTIVE, rolls_left=0, pend_v=0): en clears, and the new bet goes to pending → ARMED.
- Outputs:
  - active = (state==ACTIVE).
  - en, rolls_left and bet_err are registered.

## Timing
- Reset values:
  - en=0, active=0, rolls_left=0, bet_err=0, bet_ready=1.
  - pend_v=0, state IDLE.
  - Reset applies immediately, mid-round included.
- Handshake:
  - A bet is accepted on the rising edge where bet_valid & bet_ready.
  - bet_ready drops the cycle after a legal accept.
- Roll latency: en/active update one cycle after the roll is sampled.
- bet_err is high in the cycle after the rejected handshake, for exactly one cycle.
- Mask lifetime: a bet with hold=h keeps en live for h+1 rolls.

## Structure
- odds_pkg:
  - mode enum: MODE_THERM, MODE_ONEHOT, MODE_TOP, MODE_RSVD.
  - state enum: IDLE, ARMED, ACTIVE.
  - default LANES constant.
- Sub-module odds_mask_gen: purely combinational (bet, mode) → mask plus a legal flag, parametrised by LANES. It is instantiated once, on the bet input path.
- The top level holds the FSM, the pending register, the hold counter and the err pulse.

## Test plan
All scenarios use LANES=10 and HOLD_W=4.
- Reset, then bet 3, mode 0, hold 0, then roll: en=10'b00000_00111 one cycle after the roll, active=1; the next roll gives en=0 and IDLE.
- Bet 10 mode 2, then bet 4 mode 1, each checked with one roll: en=10'b11111_11111 for the first, en=10'b00000_01000 for the second.
- Bet 11, or bet 2 with mode 3: bet_err pulses for 1 cycle, en and state are unchanged, and bet_ready stays 1.
- Bet 5 mode 0 hold 2, plus a queued bet 1 accepted during ACTIVE: en=0x01F for 3 rolls, rolls_left goes 2,1,0, then en=0x001 on the 4th roll with no gap; bet_ready=0 while the second bet is pending.
- cancel asserted in the same cycle as roll in ARMED: en stays 0, IDLE, bet_ready=1; rst asserted while ACTIVE: en=0 immediately.
